dcache_wb_responder: RTL and testbench

//  Responder end of the pipeline's DCACHE_* request interface: direct-mapped, write-back,

---
 rtl/cache_pkg.sv | 30 +++
 rtl/cache_line_array.sv | 66 ++++++
 rtl/dcache_wb_responder.sv | 163 ++++++++++++++++
 tb/tb_dcache_wb_responder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache definitions: FSM states, block/word geometry and address-split widths
// used by both the data- and instruction-side caches.
package cache_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BLOCK_W        = 128;
    localparam int unsigned WORDS_PER_LINE = 4;
    localparam int unsigned OFFSET_W       = 2;
    localparam int unsigned ADDR_W         = 30;
    localparam int unsigned BLK_ADDR_W     = ADDR_W - OFFSET_W;

    typedef enum logic [1:0] {
        COMPARE   = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } cache_state_e;

    // Registered request presented to the block memory
    typedef struct packed {
        logic                  read;
        logic                  write;
        logic [BLK_ADDR_W-1:0] addr;
        logic [BLOCK_W-1:0]    wdata;
    } mem_req_t;

    function automatic int unsigned tag_width(input int unsigned index_w);
        return ADDR_W - OFFSET_W - index_w;
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Direct-mapped line storage: valid/dirty/tag/data per set, async read of the
// indexed line, single synchronous write port, async clear of valid/dirty.
module cache_line_array
    import cache_pkg::*;
#(
    parameter int unsigned INDEX_W = 3,
    parameter int unsigned TAG_W   = tag_width(INDEX_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] index,
    output logic               rd_valid_c,
    output logic               rd_dirty_c,
    output logic [TAG_W-1:0]   rd_tag_c,
    output logic [BLOCK_W-1:0] rd_data_c,
    input  logic               wr_en,
    input  logic               wr_valid,
    input  logic               wr_dirty,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [BLOCK_W-1:0] wr_data
);

    localparam int unsigned NUM_SETS = 1 << INDEX_W;

    logic [NUM_SETS-1:0] valid_q, valid_d;
    logic [NUM_SETS-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [TAG_W-1:0]    tag_d  [NUM_SETS];
    logic [BLOCK_W-1:0]  data_q [NUM_SETS];
    logic [BLOCK_W-1:0]  data_d [NUM_SETS];

    assign rd_valid_c = valid_q[index];
    assign rd_dirty_c = dirty_q[index];
    assign rd_tag_c   = tag_q[index];
    assign rd_data_c  = data_q[index];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            valid_d[index] = wr_valid;
            dirty_d[index] = wr_dirty;
            tag_d[index]   = wr_tag;
            data_d[index]  = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data contents are meaningless until valid is set, so no reset
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/dcache_wb_responder.sv
// Direct-mapped write-back, write-allocate data cache answering the MEM-stage
// request port; hits complete in the request cycle, misses stall through write-back/refill.
module dcache_wb_responder
    import cache_pkg::*;
#(
    parameter int unsigned INDEX_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  proc_read,
    input  logic                  proc_write,
    input  logic [ADDR_W-1:0]     proc_addr,
    input  logic [WORD_W-1:0]     proc_wdata,
    output logic                  proc_stall,
    output logic [WORD_W-1:0]     proc_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [BLK_ADDR_W-1:0] mem_addr,
    output logic [BLOCK_W-1:0]    mem_wdata,
    input  logic [BLOCK_W-1:0]    mem_rdata,
    input  logic                  mem_ready
);

    localparam int unsigned TAG_W = tag_width(INDEX_W);

    logic [OFFSET_W-1:0] offset;
    logic [INDEX_W-1:0]  index;
    logic [TAG_W-1:0]    tag;
    logic                req;
    logic                hit;

    logic                rd_valid, rd_dirty;
    logic [TAG_W-1:0]    rd_tag;
    logic [BLOCK_W-1:0]  rd_data;
    logic                wr_en, wr_valid, wr_dirty;
    logic [TAG_W-1:0]    wr_tag;
    logic [BLOCK_W-1:0]  wr_data;

    logic [WORD_W-1:0]   hit_word;
    logic [BLOCK_W-1:0]  merged_line;

    cache_state_e        state_q, state_d;
    mem_req_t            mem_req_q, mem_req_d;

    assign offset = proc_addr[OFFSET_W-1:0];
    assign index  = proc_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign tag    = proc_addr[ADDR_W-1:INDEX_W+OFFSET_W];
    assign req    = proc_read | proc_write;
    assign hit    = rd_valid & (rd_tag == tag);

    assign mem_read  = mem_req_q.read;
    assign mem_write = mem_req_q.write;
    assign mem_addr  = mem_req_q.addr;
    assign mem_wdata = mem_req_q.wdata;

    cache_line_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_lines (
        .clk        (clk),
        .rst_n      (rst_n),
        .index      (index),
        .rd_valid_c (rd_valid),
        .rd_dirty_c (rd_dirty),
        .rd_tag_c   (rd_tag),
        .rd_data_c  (rd_data),
        .wr_en      (wr_en),
        .wr_valid   (wr_valid),
        .wr_dirty   (wr_dirty),
        .wr_tag     (wr_tag),
        .wr_data    (wr_data)
    );

    // Word select for loads and word merge for stores
    always_comb begin
        hit_word    = '0;
        merged_line = rd_data;
        for (int unsigned w = 0; w < WORDS_PER_LINE; w++) begin
            if (offset == OFFSET_W'(w)) begin
                hit_word                         = rd_data[w*WORD_W +: WORD_W];
                merged_line[w*WORD_W +: WORD_W]  = proc_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= COMPARE;
            mem_req_q <= '0;
        end else begin
            state_q   <= state_d;
            mem_req_q <= mem_req_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        wr_en      = 1'b0;
        wr_valid   = rd_valid;
        wr_dirty   = rd_dirty;
        wr_tag     = rd_tag;
        wr_data    = rd_data;
        proc_stall = 1'b0;
        proc_rdata = '0;
        unique case (state_q)
            COMPARE: begin
                if (req && hit) begin
                    if (proc_write) begin
                        wr_en    = 1'b1;
                        wr_dirty = 1'b1;
                        wr_data  = merged_line;
                    end else begin
                        proc_rdata = hit_word;
                    end
                end else if (req) begin
                    proc_stall = 1'b1;
                    // Memory request goes out registered, one cycle after the miss is seen
                    if (rd_valid && rd_dirty) begin
                        state_d         = WRITEBACK;
                        mem_req_d.write = 1'b1;
                        mem_req_d.read  = 1'b0;
                        mem_req_d.addr  = {rd_tag, index};
                        mem_req_d.wdata = rd_data;
                    end else begin
                        state_d         = ALLOCATE;
                        mem_req_d.read  = 1'b1;
                        mem_req_d.write = 1'b0;
                        mem_req_d.addr  = proc_addr[ADDR_W-1:OFFSET_W];
                    end
                end
            end
            WRITEBACK: begin
                proc_stall = 1'b1;
                if (mem_ready) begin
                    wr_en           = 1'b1;
                    wr_dirty        = 1'b0;
                    state_d         = ALLOCATE;
                    mem_req_d.write = 1'b0;
                    mem_req_d.read  = 1'b1;
                    mem_req_d.addr  = proc_addr[ADDR_W-1:OFFSET_W];
                end
            end
            ALLOCATE: begin
                proc_stall = 1'b1;
                if (mem_ready) begin
                    wr_en          = 1'b1;
                    wr_valid       = 1'b1;
                    wr_dirty       = 1'b0;
                    wr_tag         = tag;
                    wr_data        = mem_rdata;
                    state_d        = COMPARE;
                    mem_req_d.read = 1'b0;
                end
            end
            default: begin
                state_d   = COMPARE;
                mem_req_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_wb_responder.sv
// Directed bench for dcache_wb_responder: per-cycle vector table for the main
// miss/hit flows plus hand sequences for write-allocate, dirty eviction and reset mid-refill.
module tb_dcache_wb_responder;

    logic         clk;
    logic         rst_n;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int unsigned n_cmp;
    int unsigned n_bad;

    dcache_wb_responder #(.INDEX_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [29:0]  addr;
        logic [31:0]  wdata;
        logic         rdy;
        logic [127:0] mrdata;
        logic         e_stall;
        logic [31:0]  e_rdata;
        logic         e_mr;
        logic         e_mw;
        logic [27:0]  e_maddr;
        logic [127:0] e_wdata;
    } vec_t;

    localparam int NV = 30;
    vec_t tv [NV];

    function automatic logic [127:0] blk(input logic [31:0] b);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    function automatic vec_t mk(input logic rd, input logic wr, input logic [29:0] a,
                                input logic [31:0] d, input logic rdy, input logic [127:0] mrd,
                                input logic e_st, input logic [31:0] e_rd, input logic e_mr,
                                input logic e_mw, input logic [27:0] e_ma, input logic [127:0] e_wd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = a; v.wdata = d; v.rdy = rdy; v.mrdata = mrd;
        v.e_stall = e_st; v.e_rdata = e_rd; v.e_mr = e_mr; v.e_mw = e_mw;
        v.e_maddr = e_ma; v.e_wdata = e_wd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] d);
        proc_read  = rd;
        proc_write = wr;
        proc_addr  = a;
        proc_wdata = d;
        #1;
    endtask

    // One-cycle mem_ready pulse spanning a single rising edge
    task automatic serve(input logic [127:0] b);
        mem_ready = 1'b1;
        mem_rdata = b;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        mem_rdata = '0;
        @(negedge clk);
    endtask

    task automatic wait_mem(input string name, input logic want_wr);
        int n = 0;
        while (!(want_wr ? mem_write : mem_read) && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({name, " req seen"}, 128'(want_wr ? mem_write : mem_read), 128'(1));
    endtask

    initial begin
        logic [127:0] b1, b2, b3, bx, wb1, wb2;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        proc_read = 1'b0; proc_write = 1'b0; proc_addr = '0; proc_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;

        b1  = blk(32'hA000_0000);
        b2  = blk(32'hB000_0000);
        b3  = blk(32'hC000_0000);
        bx  = blk(32'hEEEE_0000);
        wb1 = {32'hA000_0003, 32'hA000_0002, 32'hDEAD_BEEF, 32'hA000_0000};
        wb2 = {32'h5000_0003, 32'h5000_0002, 32'h5000_0001, 32'hCAFE_F00D};

        //          rd wr addr   wdata          rdy mrdata st rdata          mr mw maddr wdata
        tv[0]  = mk(0, 0, 30'h00, 32'h0,         0, '0,   0, 32'h0,          0, 0, 28'h0, '0);
        tv[1]  = mk(1, 0, 30'h10, 32'h0,         0, '0,   1, 32'h0,          0, 0, 28'h0, '0);
        tv[2]  = mk(1, 0, 30'h10, 32'h0,         0, '0,   1, 32'h0,          1, 0, 28'h4, '0);
        tv[3]  = mk(1, 0, 30'h10, 32'h0,         1, b1,   1, 32'h0,          1, 0, 28'h4, '0);
        tv[4]  = mk(1, 0, 30'h10, 32'h0,         0, '0,   0, 32'hA000_0000,  0, 0, 28'h0, '0);
        tv[5]  = mk(0, 1, 30'h11, 32'hDEAD_BEEF, 0, '0,   0, 32'h0,          0, 0, 28'h0, '0);
        tv[6]  = mk(1, 0, 30'h11, 32'h0,         0, '0,   0, 32'hDEAD_BEEF,  0, 0, 28'h0, '0);
        tv[7]  = mk(1, 0, 30'h13, 32'h0,         0, '0,   0, 32'hA000_0003,  0, 0, 28'h0, '0);
        tv[8]  = mk(1, 0, 30'h30, 32'h0,         0, '0,   1, 32'h0,          0, 0, 28'h0, '0);
        tv[9]  = mk(1, 0, 30'h30, 32'h0,         0, '0,   1, 32'h0,          0, 1, 28'h4, wb1);
        tv[10] = mk(1, 0, 30'h30, 32'h0,         1, '0,   1, 32'h0,          0, 1, 28'h4, wb1);
        tv[11] = mk(1, 0, 30'h30, 32'h0,         0, '0,   1, 32'h0,          1, 0, 28'hC, '0);
        tv[12] = mk(1, 0, 30'h30, 32'h0,         1, b2,   1, 32'h0,          1, 0, 28'hC, '0);
        tv[13] = mk(1, 0, 30'h30, 32'h0,         0, '0,   0, 32'hB000_0000,  0, 0, 28'h0, '0);
        tv[14] = mk(1, 0, 30'h33, 32'h0,         0, '0,   0, 32'hB000_0003,  0, 0, 28'h0, '0);
        tv[15] = mk(1, 0, 30'h34, 32'h0,         0, '0,   1, 32'h0,          0, 0, 28'h0, '0);
        tv[16] = mk(1, 0, 30'h34, 32'h0,         0, '0,   1, 32'h0,          1, 0, 28'hD, '0);
        tv[17] = mk(1, 0, 30'h34, 32'h0,         1, b3,   1, 32'h0,          1, 0, 28'hD, '0);
        for (int k = 0; k < 8; k++) begin
            tv[18+k] = mk(1, 0, 30'(32'h30 + k), 32'h0, 0, '0, 0,
                          (k < 4) ? 32'(32'hB000_0000 + k) : 32'(32'hC000_0000 + k - 4),
                          0, 0, 28'h0, '0);
        end
        tv[26] = mk(0, 0, 30'h00, 32'h0,         1, bx,   0, 32'h0,          0, 0, 28'h0, '0);
        tv[27] = mk(1, 0, 30'h34, 32'h0,         0, '0,   0, 32'hC000_0000,  0, 0, 28'h0, '0);
        tv[28] = mk(1, 1, 30'h35, 32'h1234_5678, 0, '0,   0, 32'h0,          0, 0, 28'h0, '0);
        tv[29] = mk(1, 0, 30'h35, 32'h0,         0, '0,   0, 32'h1234_5678,  0, 0, 28'h0, '0);

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            proc_read  = tv[i].rd;
            proc_write = tv[i].wr;
            proc_addr  = tv[i].addr;
            proc_wdata = tv[i].wdata;
            mem_ready  = tv[i].rdy;
            mem_rdata  = tv[i].mrdata;
            #1;
            chk($sformatf("v%0d stall", i), 128'(proc_stall), 128'(tv[i].e_stall));
            if ((tv[i].rd && !tv[i].wr && !tv[i].e_stall) || i == 0)
                chk($sformatf("v%0d rdata", i), 128'(proc_rdata), 128'(tv[i].e_rdata));
            chk($sformatf("v%0d mem_read", i), 128'(mem_read), 128'(tv[i].e_mr));
            chk($sformatf("v%0d mem_write", i), 128'(mem_write), 128'(tv[i].e_mw));
            if (tv[i].e_mr || tv[i].e_mw || i == 0)
                chk($sformatf("v%0d mem_addr", i), 128'(mem_addr), 128'(tv[i].e_maddr));
            if (tv[i].e_mw || i == 0)
                chk($sformatf("v%0d mem_wdata", i), mem_wdata, tv[i].e_wdata);
            @(negedge clk);
        end
        mem_ready = 1'b0;
        mem_rdata = '0;

        // Write miss on a clean set allocates, then the store hits
        set_req(0, 1, 30'h20, 32'hCAFE_F00D);
        chk("wa stall", 128'(proc_stall), 128'(1));
        wait_mem("wa", 1'b0);
        chk("wa addr", 128'(mem_addr), 128'(28'h8));
        chk("wa no write", 128'(mem_write), 128'(0));
        serve(blk(32'h5000_0000));
        chk("wa hit stall", 128'(proc_stall), 128'(0));
        chk("wa read drop", 128'(mem_read), 128'(0));
        @(negedge clk);
        set_req(1, 0, 30'h20, 32'h0);
        chk("wa rdata0", 128'(proc_rdata), 128'(32'hCAFE_F00D));
        set_req(1, 0, 30'h21, 32'h0);
        chk("wa rdata1", 128'(proc_rdata), 128'(32'h5000_0001));

        // Write miss on a dirty set: eviction of the merged line, then refill
        set_req(0, 1, 30'h40, 32'h0BAD_CAFE);
        chk("ev stall", 128'(proc_stall), 128'(1));
        wait_mem("ev wb", 1'b1);
        chk("ev wb addr", 128'(mem_addr), 128'(28'h8));
        chk("ev wb data", mem_wdata, wb2);
        chk("ev wb no read", 128'(mem_read), 128'(0));
        serve('0);
        wait_mem("ev fill", 1'b0);
        chk("ev fill addr", 128'(mem_addr), 128'(28'h10));
        chk("ev fill no write", 128'(mem_write), 128'(0));
        serve(blk(32'h6000_0000));
        chk("ev hit stall", 128'(proc_stall), 128'(0));
        @(negedge clk);
        set_req(1, 0, 30'h40, 32'h0);
        chk("ev rdata0", 128'(proc_rdata), 128'(32'h0BAD_CAFE));
        set_req(1, 0, 30'h43, 32'h0);
        chk("ev rdata3", 128'(proc_rdata), 128'(32'h6000_0003));

        // Reset in the middle of a refill
        set_req(1, 0, 30'h50, 32'h0);
        chk("rs stall", 128'(proc_stall), 128'(1));
        wait_mem("rs", 1'b0);
        chk("rs addr", 128'(mem_addr), 128'(28'h14));
        #1 rst_n = 1'b0;
        #1;
        chk("rs mem_read async", 128'(mem_read), 128'(0));
        chk("rs mem_write async", 128'(mem_write), 128'(0));
        chk("rs mem_addr async", 128'(mem_addr), 128'(0));
        set_req(0, 0, 30'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        set_req(1, 0, 30'h50, 32'h0);
        chk("rs re-miss", 128'(proc_stall), 128'(1));
        wait_mem("rs refill", 1'b0);
        chk("rs refill addr", 128'(mem_addr), 128'(28'h14));
        serve(blk(32'h7000_0000));
        chk("rs hit stall", 128'(proc_stall), 128'(0));
        chk("rs hit rdata", 128'(proc_rdata), 128'(32'h7000_0000));
        set_req(1, 0, 30'h34, 32'h0);
        chk("rs cleared line", 128'(proc_stall), 128'(1));
        wait_mem("rs clean", 1'b0);
        chk("rs no writeback", 128'(mem_write), 128'(0));
        chk("rs clean addr", 128'(mem_addr), 128'(28'hD));
        serve(blk(32'h8000_0000));
        set_req(1, 0, 30'h35, 32'h0);
        chk("rs clean rdata", 128'(proc_rdata), 128'(32'h8000_0001));
        set_req(0, 0, 30'h0, 32'h0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
